// File: rtl/interboard_tx_scheduler_pkg.sv
// Shared definitions for the interboard transmit scheduler:
// 22-bit message packing, msg_type codes, FSM states and requester ids.
package interboard_tx_scheduler_pkg;

  localparam int MSG_W = 22;

  // {move_dir, msg_type, block_x, block_y, card, sel_len}
  localparam int MOVE_DIR_BIT = 21;
  localparam int MSG_TYPE_LSB = 17;
  localparam int MSG_TYPE_W   = 4;
  localparam int BLOCK_X_LSB  = 12;
  localparam int BLOCK_X_W    = 5;
  localparam int BLOCK_Y_LSB  = 9;
  localparam int BLOCK_Y_W    = 3;
  localparam int CARD_LSB     = 3;
  localparam int CARD_W       = 6;
  localparam int SEL_LEN_LSB  = 0;
  localparam int SEL_LEN_W    = 3;

  localparam logic [MSG_TYPE_W-1:0] MT_NOP    = 4'h0;
  localparam logic [MSG_TYPE_W-1:0] MT_MOVE   = 4'h1;
  localparam logic [MSG_TYPE_W-1:0] MT_PLACE  = 4'h2;
  localparam logic [MSG_TYPE_W-1:0] MT_SELECT = 4'h3;
  localparam logic [MSG_TYPE_W-1:0] MT_SYNC   = 4'h4;
  localparam logic [MSG_TYPE_W-1:0] MT_MEMRD  = 4'h8;
  localparam logic [MSG_TYPE_W-1:0] MT_MEMWR  = 4'h9;

  typedef logic [MSG_W-1:0] msg_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BUSY = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_e;

  typedef enum logic {
    SRC_GC = 1'b0,
    SRC_MH = 1'b1
  } src_e;

endpackage

// File: rtl/interboard_tx_scheduler_rr_arbiter2.sv
// Two-input round-robin arbiter: combinational grant, registered last-grant pointer.
// Bit 0 of req/grant is game control, bit 1 is memory handle.
module interboard_tx_scheduler_rr_arbiter2
  import interboard_tx_scheduler_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] req,
  input  logic       update,
  input  src_e       update_src,
  output logic [1:0] grant
);

  src_e last_grant_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_grant_reg <= SRC_MH;
    end else if (update) begin
      last_grant_reg <= update_src;
    end
  end

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      if (req == 2'b11) begin
        grant = (last_grant_reg == SRC_GC) ? 2'b10 : 2'b01;
      end else begin
        grant = req;
      end
    end
  end

endmodule

// File: rtl/interboard_tx_scheduler.sv
// Issues one message at a time from game control or memory handle to the
// interboard link, with accept timeout, bounded retry and flush.
module interboard_tx_scheduler
  import interboard_tx_scheduler_pkg::*;
#(
  parameter int ACCEPT_TIMEOUT = 1024,
  parameter int MAX_RETRY      = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             interboard_rst,
  input  logic             send_ready,
  input  logic             gc_valid,
  input  logic             mh_valid,
  input  logic [MSG_W-1:0] gc_msg,
  input  logic [MSG_W-1:0] mh_msg,
  output logic             gc_ready,
  output logic             mh_ready,
  output logic             tx_transmit,
  output logic [MSG_W-1:0] tx_msg,
  output logic             tx_busy,
  output logic             link_err
);

  localparam int CNT_W   = $clog2(ACCEPT_TIMEOUT + 1);
  localparam int RETRY_W = $clog2(MAX_RETRY + 2);
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(ACCEPT_TIMEOUT - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  state_e             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [RETRY_W-1:0] retry_reg, retry_next;
  logic               tx_transmit_reg, tx_transmit_next;
  logic               link_err_reg, link_err_next;
  msg_t               tx_msg_reg, tx_msg_next;
  src_e               src_reg, src_next;

  logic       grant_en;
  logic [1:0] grant;
  logic       last_update;

  // Readies only while idle with an idle link, and never during reset or flush.
  assign grant_en = (state_reg == ST_IDLE) && send_ready && !interboard_rst && rst;

  interboard_tx_scheduler_rr_arbiter2 u_arb (
    .clk        (clk),
    .rst        (rst),
    .enable     (grant_en),
    .req        ({mh_valid, gc_valid}),
    .update     (last_update),
    .update_src (src_reg),
    .grant      (grant)
  );

  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    retry_next       = retry_reg;
    tx_transmit_next = 1'b0;
    link_err_next    = link_err_reg;
    tx_msg_next      = tx_msg_reg;
    src_next         = src_reg;
    last_update      = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (grant != 2'b00) begin
          src_next         = grant[1] ? SRC_MH : SRC_GC;
          tx_msg_next      = grant[1] ? mh_msg : gc_msg;
          tx_transmit_next = 1'b1;
          cnt_next         = '0;
          retry_next       = '0;
          state_next       = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        // A falling send_ready wins over a simultaneous timeout.
        if (!send_ready) begin
          cnt_next   = '0;
          retry_next = '0;
          state_next = ST_WAIT_DONE;
        end else if (cnt_reg == CNT_LAST) begin
          cnt_next = '0;
          if (retry_reg < RETRY_MAX) begin
            tx_transmit_next = 1'b1;
            retry_next       = retry_reg + RETRY_W'(1);
          end else begin
            link_err_next = 1'b1;
            retry_next    = '0;
            state_next    = ST_IDLE;
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (send_ready) begin
          last_update = 1'b1;
          state_next  = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Flush keeps the round-robin pointer but discards everything in flight.
    if (interboard_rst) begin
      state_next       = ST_IDLE;
      cnt_next         = '0;
      retry_next       = '0;
      tx_transmit_next = 1'b0;
      link_err_next    = 1'b0;
      tx_msg_next      = '0;
      last_update      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg       <= ST_IDLE;
      cnt_reg         <= '0;
      retry_reg       <= '0;
      tx_transmit_reg <= 1'b0;
      link_err_reg    <= 1'b0;
      tx_msg_reg      <= '0;
      src_reg         <= SRC_MH;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      retry_reg       <= retry_next;
      tx_transmit_reg <= tx_transmit_next;
      link_err_reg    <= link_err_next;
      tx_msg_reg      <= tx_msg_next;
      src_reg         <= src_next;
    end
  end

  assign gc_ready    = grant[0];
  assign mh_ready    = grant[1];
  assign tx_transmit = tx_transmit_reg;
  assign tx_msg      = tx_msg_reg;
  assign tx_busy     = (state_reg != ST_IDLE);
  assign link_err    = link_err_reg;

endmodule

// File: tb/tb_interboard_tx_scheduler.sv
// Self-checking bench for interboard_tx_scheduler: directed scenarios plus
// randomized traffic checked against a transaction-level round-robin model.
module tb_interboard_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        interboard_rst = 1'b0;
  logic        send_ready = 1'b0;
  logic        gc_valid = 1'b0;
  logic        mh_valid = 1'b0;
  logic [21:0] gc_msg = '0;
  logic [21:0] mh_msg = '0;
  logic        gc_ready, mh_ready, tx_transmit, tx_busy, link_err;
  logic [21:0] tx_msg;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [21:0] gq[$];
  logic [21:0] mq[$];

  interboard_tx_scheduler #(.ACCEPT_TIMEOUT(8), .MAX_RETRY(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .interboard_rst (interboard_rst),
    .send_ready     (send_ready),
    .gc_valid       (gc_valid),
    .mh_valid       (mh_valid),
    .gc_msg         (gc_msg),
    .mh_msg         (mh_msg),
    .gc_ready       (gc_ready),
    .mh_ready       (mh_ready),
    .tx_transmit    (tx_transmit),
    .tx_msg         (tx_msg),
    .tx_busy        (tx_busy),
    .link_err       (link_err)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0; interboard_rst = 1'b0; gc_valid = 1'b0; mh_valid = 1'b0; send_ready = 1'b1;
    cyc(); cyc();
    rst = 1'b1;
    cyc();
  endtask

  // Link accepts: busy for two cycles then idle again; ends in an IDLE cycle.
  task automatic handshake();
    cyc(); send_ready = 1'b0;
    cyc();
    cyc(); send_ready = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    rst = 1'b0; gc_valid = 1'b1; send_ready = 1'b1; gc_msg = 22'h3FFFFF;
    cyc(); cyc();
    #1;
    total_cnt++; if (gc_ready !== 1'b0) $display("FAIL reset_gc_ready: got %b expected 0", gc_ready); else pass_cnt++;
    total_cnt++; if (mh_ready !== 1'b0) $display("FAIL reset_mh_ready: got %b expected 0", mh_ready); else pass_cnt++;
    total_cnt++; if (tx_transmit !== 1'b0) $display("FAIL reset_tx_transmit: got %b expected 0", tx_transmit); else pass_cnt++;
    total_cnt++; if (tx_msg !== 22'h0) $display("FAIL reset_tx_msg: got %h expected 000000", tx_msg); else pass_cnt++;
    total_cnt++; if (tx_busy !== 1'b0) $display("FAIL reset_tx_busy: got %b expected 0", tx_busy); else pass_cnt++;
    total_cnt++; if (link_err !== 1'b0) $display("FAIL reset_link_err: got %b expected 0", link_err); else pass_cnt++;
    cyc();
    gc_valid = 1'b0; rst = 1'b1;
    cyc();
  endtask

  task automatic test_single();
    int pulses = 0;
    int busy_bad = 0;
    int msg_bad = 0;
    logic first_pulse = 1'b0;
    send_ready = 1'b1; gc_valid = 1'b1; gc_msg = 22'h15A5A3; mh_valid = 1'b0;
    #1;
    total_cnt++; if (gc_ready !== 1'b1 || mh_ready !== 1'b0) $display("FAIL single_grant: got gc=%b mh=%b expected gc=1 mh=0", gc_ready, mh_ready); else pass_cnt++;
    total_cnt++; if (tx_transmit !== 1'b0) $display("FAIL single_no_early_tx: got %b expected 0", tx_transmit); else pass_cnt++;
    cyc(); gc_valid = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      if (k == 3) send_ready = 1'b0;
      if (k == 13) send_ready = 1'b1;
      #1;
      if (k == 1) first_pulse = tx_transmit;
      if (tx_transmit === 1'b1) pulses++;
      if (tx_busy !== 1'b1) busy_bad++;
      if (tx_msg !== 22'h15A5A3) msg_bad++;
      cyc();
    end
    #1;
    total_cnt++; if (first_pulse !== 1'b1) $display("FAIL single_tx_at_c1: got %b expected 1", first_pulse); else pass_cnt++;
    total_cnt++; if (pulses != 1) $display("FAIL single_pulse_count: got %0d expected 1", pulses); else pass_cnt++;
    total_cnt++; if (busy_bad != 0) $display("FAIL single_busy_during_txn: got %0d idle cycles expected 0", busy_bad); else pass_cnt++;
    total_cnt++; if (msg_bad != 0) $display("FAIL single_tx_msg_stable: got %0d bad cycles expected 0", msg_bad); else pass_cnt++;
    total_cnt++; if (tx_busy !== 1'b0) $display("FAIL single_back_idle: got tx_busy=%b expected 0", tx_busy); else pass_cnt++;
    $display("txn single: src=gc msg=%h", 22'h15A5A3);
  endtask

  task automatic test_tie();
    logic [21:0] exp_msg;
    apply_reset();
    gc_msg = 22'h0ABCDE; mh_msg = 22'h2F0F0F;
    gc_valid = 1'b1; mh_valid = 1'b1; send_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      exp_msg = (i % 2 == 0) ? gc_msg : mh_msg;
      total_cnt++;
      if ({mh_ready, gc_ready} !== ((i % 2 == 0) ? 2'b01 : 2'b10))
        $display("FAIL tie_order_%0d: got mh,gc=%b%b expected %s", i, mh_ready, gc_ready, (i % 2 == 0) ? "gc" : "mh");
      else pass_cnt++;
      cyc();
      #1;
      total_cnt++; if (tx_transmit !== 1'b1 || tx_msg !== exp_msg) $display("FAIL tie_tx_%0d: got tx=%b msg=%h expected tx=1 msg=%h", i, tx_transmit, tx_msg, exp_msg); else pass_cnt++;
      $display("txn tie %0d: src=%s msg=%h", i, (i % 2 == 0) ? "gc" : "mh", tx_msg);
      handshake();
    end
    gc_valid = 1'b0; mh_valid = 1'b0;
  endtask

  task automatic test_blocked();
    int bad = 0;
    send_ready = 1'b0; gc_valid = 1'b1; gc_msg = 22'h123456;
    for (int k = 0; k < 50; k++) begin
      #1;
      if (gc_ready !== 1'b0 || mh_ready !== 1'b0 || tx_transmit !== 1'b0) bad++;
      cyc();
    end
    total_cnt++; if (bad != 0) $display("FAIL blocked_quiet: got %0d active cycles expected 0", bad); else pass_cnt++;
    send_ready = 1'b1;
    #1;
    total_cnt++; if (gc_ready !== 1'b1) $display("FAIL blocked_release_grant: got %b expected 1", gc_ready); else pass_cnt++;
    cyc(); gc_valid = 1'b0;
    #1;
    total_cnt++; if (tx_transmit !== 1'b1 || tx_msg !== 22'h123456) $display("FAIL blocked_tx: got tx=%b msg=%h expected tx=1 msg=123456", tx_transmit, tx_msg); else pass_cnt++;
    $display("txn blocked: src=gc msg=%h", tx_msg);
    handshake();
  endtask

  task automatic test_timeout();
    int pulses[$];
    int err_off = -1;
    int idle_off = -1;
    int msg_bad = 0;
    send_ready = 1'b1; gc_valid = 1'b1; gc_msg = 22'h2A5A5A;
    #1;
    total_cnt++; if (gc_ready !== 1'b1) $display("FAIL timeout_grant: got %b expected 1", gc_ready); else pass_cnt++;
    cyc(); gc_valid = 1'b0;
    for (int off = 1; off <= 40; off++) begin
      #1;
      if (tx_transmit === 1'b1) begin
        pulses.push_back(off);
        if (tx_msg !== 22'h2A5A5A) msg_bad++;
      end
      if (link_err === 1'b1 && err_off < 0) err_off = off;
      if (tx_busy === 1'b0 && idle_off < 0) idle_off = off;
      cyc();
    end
    total_cnt++; if (pulses.size() != 4) $display("FAIL timeout_pulse_count: got %0d expected 4", pulses.size()); else pass_cnt++;
    for (int k = 0; k < pulses.size() && k < 4; k++) begin
      total_cnt++; if (pulses[k] != 1 + 8 * k) $display("FAIL timeout_pulse_%0d: got offset %0d expected %0d", k, pulses[k], 1 + 8 * k); else pass_cnt++;
    end
    total_cnt++; if (msg_bad != 0) $display("FAIL timeout_msg_stable: got %0d bad pulses expected 0", msg_bad); else pass_cnt++;
    total_cnt++; if (err_off != 33) $display("FAIL timeout_link_err: got offset %0d expected 33", err_off); else pass_cnt++;
    total_cnt++; if (idle_off != 33) $display("FAIL timeout_idle: got offset %0d expected 33", idle_off); else pass_cnt++;
    #1;
    total_cnt++; if (link_err !== 1'b1) $display("FAIL timeout_err_sticky: got %b expected 1", link_err); else pass_cnt++;
    $display("txn timeout: src=gc msg=%h dropped after %0d pulses", 22'h2A5A5A, pulses.size());
  endtask

  task automatic test_flush();
    send_ready = 1'b1; gc_valid = 1'b1; gc_msg = 22'h011111; mh_valid = 1'b0;
    #1;
    total_cnt++; if (gc_ready !== 1'b1) $display("FAIL flush_gc_grant: got %b expected 1", gc_ready); else pass_cnt++;
    cyc(); gc_valid = 1'b0; mh_valid = 1'b1; mh_msg = 22'h3C3C3C;
    cyc(); send_ready = 1'b0;
    cyc();
    cyc(); interboard_rst = 1'b1;
    #1;
    total_cnt++; if (mh_ready !== 1'b0) $display("FAIL flush_no_ready_busy: got %b expected 0", mh_ready); else pass_cnt++;
    cyc(); send_ready = 1'b1;
    #1;
    total_cnt++; if (tx_busy !== 1'b0) $display("FAIL flush_idle: got tx_busy=%b expected 0", tx_busy); else pass_cnt++;
    total_cnt++; if (link_err !== 1'b0) $display("FAIL flush_link_err: got %b expected 0", link_err); else pass_cnt++;
    total_cnt++; if (tx_msg !== 22'h0) $display("FAIL flush_msg_discard: got %h expected 000000", tx_msg); else pass_cnt++;
    total_cnt++; if (mh_ready !== 1'b0) $display("FAIL flush_priority: got mh_ready=%b expected 0", mh_ready); else pass_cnt++;
    cyc(); interboard_rst = 1'b0;
    #1;
    total_cnt++; if (mh_ready !== 1'b1 || gc_ready !== 1'b0) $display("FAIL flush_pending_mh: got mh=%b gc=%b expected mh=1 gc=0", mh_ready, gc_ready); else pass_cnt++;
    cyc(); mh_valid = 1'b0;
    #1;
    total_cnt++; if (tx_transmit !== 1'b1 || tx_msg !== 22'h3C3C3C) $display("FAIL flush_mh_tx: got tx=%b msg=%h expected tx=1 msg=3c3c3c", tx_transmit, tx_msg); else pass_cnt++;
    $display("txn flush: src=mh msg=%h", tx_msg);
    handshake();
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    send_ready = 1'b1; gc_valid = 1'b1; gc_msg = 22'h0F0F0F;
    #1;
    total_cnt++; if (gc_ready !== 1'b1) $display("FAIL rmid_grant: got %b expected 1", gc_ready); else pass_cnt++;
    cyc(); gc_valid = 1'b0;
    cyc();
    cyc(); rst = 1'b0;
    cyc(); rst = 1'b1;
    total_cnt++;
    if (tx_busy !== 1'b0 || tx_transmit !== 1'b0 || tx_msg !== 22'h0 || link_err !== 1'b0)
      $display("FAIL rmid_clear: got busy=%b tx=%b msg=%h err=%b expected all 0", tx_busy, tx_transmit, tx_msg, link_err);
    else pass_cnt++;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (tx_transmit === 1'b1) pulses++;
      cyc();
    end
    total_cnt++; if (pulses != 0) $display("FAIL rmid_no_transmit: got %0d pulses expected 0", pulses); else pass_cnt++;
  endtask

  task automatic set_valids();
    gc_valid = (gq.size() > 0);
    mh_valid = (mq.size() > 0);
    gc_msg = (gq.size() > 0) ? gq[0] : 22'h0;
    mh_msg = (mq.size() > 0) ? mq[0] : 22'h0;
  endtask

  task automatic test_back_to_back();
    int model_last;
    int exp_w, got_w, wait_cnt, hi, lo, bad_ready, txns, guard;
    logic [21:0] exp_msg;
    apply_reset();
    model_last = 1;
    bad_ready = 0; txns = 0; guard = 0;
    for (int i = 0; i < 6; i++) gq.push_back(22'($urandom));
    for (int i = 0; i < 5; i++) mq.push_back(22'($urandom));
    send_ready = 1'b1;
    while ((gq.size() + mq.size()) > 0 && guard < 30) begin
      guard++;
      set_valids();
      #1;
      wait_cnt = 0;
      while (!(gc_ready === 1'b1 || mh_ready === 1'b1) && wait_cnt < 20) begin
        cyc(); #1; wait_cnt++;
      end
      total_cnt++; if (wait_cnt != 0) $display("FAIL b2b_latency_%0d: got %0d wait cycles expected 0", txns, wait_cnt); else pass_cnt++;
      if (wait_cnt >= 20) break;
      if (gq.size() > 0 && mq.size() > 0) exp_w = 1 - model_last;
      else exp_w = (gq.size() > 0) ? 0 : 1;
      got_w = (gc_ready === 1'b1) ? 0 : 1;
      total_cnt++;
      if (got_w != exp_w || (gc_ready === 1'b1 && mh_ready === 1'b1))
        $display("FAIL b2b_winner_%0d: got gc=%b mh=%b expected %s", txns, gc_ready, mh_ready, exp_w ? "mh" : "gc");
      else pass_cnt++;
      exp_msg = exp_w ? mq.pop_front() : gq.pop_front();
      model_last = exp_w;
      cyc(); set_valids();
      #1;
      total_cnt++; if (tx_transmit !== 1'b1 || tx_msg !== exp_msg) $display("FAIL b2b_tx_%0d: got tx=%b msg=%h expected tx=1 msg=%h", txns, tx_transmit, tx_msg, exp_msg); else pass_cnt++;
      $display("txn b2b %0d: src=%s msg=%h", txns, exp_w ? "mh" : "gc", tx_msg);
      if (gc_ready === 1'b1 || mh_ready === 1'b1) bad_ready++;
      hi = $urandom_range(0, 3);
      lo = $urandom_range(1, 4);
      for (int k = 0; k < hi; k++) begin
        cyc(); #1; if (gc_ready === 1'b1 || mh_ready === 1'b1) bad_ready++;
      end
      for (int k = 0; k < lo; k++) begin
        cyc(); send_ready = 1'b0; #1; if (gc_ready === 1'b1 || mh_ready === 1'b1) bad_ready++;
      end
      cyc(); send_ready = 1'b1; #1; if (gc_ready === 1'b1 || mh_ready === 1'b1) bad_ready++;
      cyc();
      txns++;
    end
    total_cnt++; if (txns != 11) $display("FAIL b2b_all_delivered: got %0d expected 11", txns); else pass_cnt++;
    total_cnt++; if (bad_ready != 0) $display("FAIL b2b_ready_while_busy: got %0d expected 0", bad_ready); else pass_cnt++;
    gc_valid = 1'b0; mh_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_blocked();
    test_timeout();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/interboard_tx_scheduler.md
# interboard_tx_scheduler

Arbitrates between the two local message sources, game control and memory handle, for the single outbound interboard link. It issues one message at a time to the interboard communication block and waits for that block's `send_ready` busy/idle cycle before issuing the next. It sits between GameControl_top / MemoryHandle_top and InterboardCommunication_top. It also retries or drops a message the link never accepts, and flushes on `interboard_rst`.

## Interface
Parameters:
- `ACCEPT_TIMEOUT`, default 1024: cycles to wait for `send_ready` to fall after an issue.
- `MAX_RETRY`, default 3: re-issues before the message is dropped.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-low reset.
- `interboard_rst`  in  1  synchronous flush, active-high.
- `send_ready`  in  1  link idle flag from interboard communication.
- `gc_valid`, `mh_valid`  in  1 each  request from game control / memory handle; held high until accepted.
- `gc_msg`, `mh_msg`  in  22 each  packed message {move_dir[21], msg_type[20:17], block_x[16:12], block_y[11:9], card[8:3], sel_len[2:0]}.
- `gc_ready`, `mh_ready`  out  1 each  accept strobe.
- `tx_transmit`  out  1  one-cycle issue pulse to the link.
- `tx_msg`  out  22  latched message; stable from issue until return to IDLE.
- `tx_busy`  out  1  high in any state other than IDLE.
- `link_err`  out  1  sticky flag: a message was dropped after retries.

## Operation
- States: IDLE, WAIT_BUSY, WAIT_DONE.
- IDLE, grant:
  - A grant occurs when `send_ready`=1 and at least one valid is high.
  - Only one requester valid: it wins.
  - Both valid: the requester not granted last wins (round-robin).
  - `last_grant` resets to mh, so gc wins the first tie.
- Grant cycle C:
  - The winner's ready is high combinationally in C; the message is latched at the end of C.
  - C+1: `tx_transmit`=1 and the state moves to WAIT_BUSY.
- WAIT_BUSY:
  - Cycle counter counts from 0.
  - If `send_ready`=0: go to WAIT_DONE and clear the counter and retry count.
  - If the counter reaches ACCEPT_TIMEOUT-1 and retry count < MAX_RETRY: pulse `tx_transmit` again, increment retry count, zero the counter.
  - If the counter reaches ACCEPT_TIMEOUT-1 and retry count = MAX_RETRY: set `link_err`, drop the message, go to IDLE.
- WAIT_DONE: when `send_ready`=1, update `last_grant` and go to IDLE.
- Readies are never high outside IDLE, and never high while `send_ready`=0.
- `interboard_rst`=1 in any state:
  - State goes to IDLE; counter, retry count and `link_err` clear.
  - The latched message is discarded; no ready is asserted that cycle.
  - `last_grant` is kept.
- Requesters keep valid high; an unaccepted request is never lost.

## Timing
- Reset (`rst`=0 at a clk edge) sets IDLE, all outputs to 0, `tx_msg`=0, and `last_grant`=mh.
- Issue latency: valid high with IDLE and `send_ready` high at cycle C gives `tx_transmit` at C+1.
- Throughput limit: the earliest next grant is the cycle after `send_ready` returns high. With a back-to-back request, the next grant is combinational in the IDLE cycle.
- Reset and flush take priority over all other events in the same cycle.
- `send_ready` falling in the same cycle the counter expires counts as an accept: no retry.
- `tx_msg` never changes during a retry.

## Structure
- Shared include `interboard_defs.vh` holds:
  - message field widths and bit offsets (22-bit packing);
  - `msg_type` codes;
  - state encodings.
- Sub-module `rr_arbiter2`: 2-input round-robin grant with a `last_grant` register and an update enable. Combinational grant, registered pointer.
- Expected size: about 200 lines of RTL.

## Test plan
- Single request:
  - gc_valid with msg 22'h15A5A3 and `send_ready`=1 gives gc_ready at C and `tx_transmit` at C+1 with `tx_msg`=22'h15A5A3.
  - Drop `send_ready` 3 cycles later, raise it 10 cycles later: state returns to IDLE, `tx_busy`=0.
- Simultaneous requests:
  - gc and mh valid together after reset: gc is granted first, mh second.
  - Repeated ties alternate gc, mh, gc.
- Blocked link:
  - `send_ready`=0 while gc_valid=1 for 50 cycles: no ready, no transmit.
  - Raise `send_ready`: grant on the same cycle.
- Timeout with ACCEPT_TIMEOUT=8, MAX_RETRY=3 and `send_ready` stuck high:
  - Exactly 4 `tx_transmit` pulses, 8 cycles apart.
  - `link_err` is set, then the scheduler returns to IDLE.
- Flush: `interboard_rst` pulsed in WAIT_DONE gives IDLE next cycle with `link_err`=0, and the pending mh request is granted afterward.
- Reset mid-operation: `rst`=0 during WAIT_BUSY clears all outputs on the next edge, and no further `tx_transmit` is issued.
